tank_shot_engine: RTL and testbench

Projectile stage for the tank. It sits between the button inputs and tank position on one side, and the display controller and monster controllers on the other. It turns `up` presses into upward-travelling shots, up to `NUM_SHOTS` at once. It detects collisions against the five monster boxes, issues per-monster hit pulses, keeps a score, and drives a shot-pixel layer for the RGB mux.

---
 rtl/tank_shot_engine.sv | 141 ++++++++++++++
 tb/tb_tank_shot_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_shot_engine.sv
// Tank projectile engine: launches shots on up presses, flies them upward,
// tests them against the monster boxes, pulses hits, keeps score, draws shot pixels.
module tank_shot_engine #(
    parameter int unsigned NUM_SHOTS = 4,
    parameter int unsigned SPEED     = 4,
    parameter int unsigned COOLDOWN  = 8,
    parameter int unsigned TOP_Y     = 40,
    parameter int unsigned SPAWN_OFS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up,
    input  logic [9:0]           tank_x,
    input  logic [9:0]           tank_y,
    input  logic [49:0]          mons_x,
    input  logic [49:0]          mons_y,
    input  logic [4:0]           mons_alive,
    input  logic [9:0]           hCount,
    input  logic [9:0]           vCount,
    output logic                 shot_pix,
    output logic [4:0]           hit,
    output logic [7:0]           score,
    output logic [NUM_SHOTS-1:0] shots_active
);

    localparam int unsigned CW       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam int unsigned NUM_MONS = 5;
    localparam logic [10:0] EXIT_Y   = 11'(TOP_Y + SPEED);

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
    } slot_t;

    slot_t          slot_q [NUM_SHOTS];
    logic           up_q;
    logic [CW-1:0]  cd_q;

    logic [4:0]           slot_mon_c [NUM_SHOTS];
    logic [NUM_SHOTS-1:0] slot_clear_c;
    logic [NUM_SHOTS-1:0] launch_sel_c;
    logic [4:0]           hit_c;
    logic [2:0]           hit_cnt_c;
    logic [8:0]           score_sum_c;
    logic                 fire_req_c;
    logic                 launch_c;
    logic [9:0]           spawn_y_c;

    // |a - b| <= r evaluated in 11 bits with offsets only on the right-hand side
    function automatic logic near(input logic [9:0] a, input logic [9:0] b, input logic [10:0] r);
        return ({1'b0, a} <= {1'b0, b} + r) && ({1'b0, b} <= {1'b0, a} + r);
    endfunction

    // Per-slot collision (lowest monster wins) and top-exit decisions
    always_comb begin
        hit_c        = '0;
        hit_cnt_c    = '0;
        slot_clear_c = '0;
        for (int i = 0; i < int'(NUM_SHOTS); i++) begin
            slot_mon_c[i] = '0;
            if (slot_q[i].valid) begin
                for (int m = int'(NUM_MONS) - 1; m >= 0; m--) begin
                    if (mons_alive[m] &&
                        near(slot_q[i].x, mons_x[10*m +: 10], 11'd5) &&
                        near(slot_q[i].y, mons_y[10*m +: 10], 11'd2)) begin
                        slot_mon_c[i]    = '0;
                        slot_mon_c[i][m] = 1'b1;
                    end
                end
                slot_clear_c[i] = (|slot_mon_c[i]) || ({1'b0, slot_q[i].y} < EXIT_Y);
            end
            hit_c = hit_c | slot_mon_c[i];
        end
        for (int m = 0; m < int'(NUM_MONS); m++) begin
            hit_cnt_c = hit_cnt_c + 3'(hit_c[m]);
        end
        score_sum_c = {1'b0, score} + 9'(hit_cnt_c);
    end

    // Launch arbitration: lowest free slot, edge-detected button, cooldown gate
    always_comb begin
        launch_sel_c = '0;
        for (int i = int'(NUM_SHOTS) - 1; i >= 0; i--) begin
            if (!slot_q[i].valid) begin
                launch_sel_c    = '0;
                launch_sel_c[i] = 1'b1;
            end
        end
        fire_req_c = up & ~up_q;
        launch_c   = fire_req_c && (cd_q == '0) && (|launch_sel_c);
        spawn_y_c  = tank_y - 10'(SPAWN_OFS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q  <= 1'b0;
            cd_q  <= '0;
            hit   <= '0;
            score <= '0;
            for (int i = 0; i < int'(NUM_SHOTS); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            up_q  <= up;
            hit   <= hit_c;
            score <= score_sum_c[8] ? 8'hFF : score_sum_c[7:0];
            if (launch_c) begin
                cd_q <= CW'(COOLDOWN);
            end else if (cd_q != '0) begin
                cd_q <= cd_q - CW'(1);
            end
            for (int i = 0; i < int'(NUM_SHOTS); i++) begin
                if (slot_q[i].valid) begin
                    if (slot_clear_c[i]) begin
                        slot_q[i].valid <= 1'b0;
                    end else begin
                        slot_q[i].y <= slot_q[i].y - 10'(SPEED);
                    end
                end else if (launch_c && launch_sel_c[i]) begin
                    slot_q[i] <= '{valid: 1'b1, x: tank_x, y: spawn_y_c};
                end
            end
        end
    end

    // Shot sprite is 3 wide by 4 tall, anchored at its top row
    always_comb begin
        shot_pix = 1'b0;
        for (int i = 0; i < int'(NUM_SHOTS); i++) begin
            shots_active[i] = slot_q[i].valid;
            if (slot_q[i].valid &&
                near(slot_q[i].x, hCount, 11'd1) &&
                (slot_q[i].y <= vCount) &&
                ({1'b0, vCount} <= {1'b0, slot_q[i].y} + 11'd3)) begin
                shot_pix = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tank_shot_engine.sv
// Bench for tank_shot_engine: rule-level shot model compared every cycle,
// plus directed scenarios with hand-computed positions and hit timing.
`timescale 1ns/1ps
module tb_tank_shot_engine;

    localparam int NS        = 4;
    localparam int SPEED     = 4;
    localparam int COOLDOWN  = 8;
    localparam int TOP_Y     = 40;
    localparam int SPAWN_OFS = 2;

    logic          clk;
    logic          rst;
    logic          up;
    logic [9:0]    tank_x, tank_y;
    logic [49:0]   mons_x, mons_y;
    logic [4:0]    mons_alive;
    logic [9:0]    hCount, vCount;
    logic          shot_pix;
    logic [4:0]    hit;
    logic [7:0]    score;
    logic [NS-1:0] shots_active;

    int checks = 0;
    int errors = 0;

    // Model state
    int   m_valid [NS];
    int   m_x     [NS];
    int   m_y     [NS];
    int   m_cd, m_upq, m_score;
    int   m_hit;

    tank_shot_engine #(
        .NUM_SHOTS(NS), .SPEED(SPEED), .COOLDOWN(COOLDOWN),
        .TOP_Y(TOP_Y), .SPAWN_OFS(SPAWN_OFS)
    ) dut (
        .clk(clk), .rst(rst), .up(up),
        .tank_x(tank_x), .tank_y(tank_y),
        .mons_x(mons_x), .mons_y(mons_y), .mons_alive(mons_alive),
        .hCount(hCount), .vCount(vCount),
        .shot_pix(shot_pix), .hit(hit), .score(score), .shots_active(shots_active)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic int model_active();
        int v = 0;
        for (int i = 0; i < NS; i++) if (m_valid[i] != 0) v |= (1 << i);
        return v;
    endfunction

    function automatic int model_pix(input int h, input int v);
        for (int i = 0; i < NS; i++)
            if (m_valid[i] != 0 && iabs(h - m_x[i]) <= 1 && v >= m_y[i] && v <= m_y[i] + 3)
                return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0; m_upq = 0; m_score = 0; m_hit = 0;
    endtask

    // One game tick from the rules: collide or retire or move, then maybe launch
    task automatic model_step();
        int free = -1;
        int newhit = 0;
        int cnt = 0;
        for (int i = 0; i < NS; i++) if (m_valid[i] == 0 && free < 0) free = i;
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i] != 0) begin
                int found = -1;
                for (int m = 0; m < 5; m++) begin
                    int mx = int'(mons_x[10*m +: 10]);
                    int my = int'(mons_y[10*m +: 10]);
                    if (found < 0 && mons_alive[m] &&
                        iabs(m_x[i] - mx) <= 5 && iabs(m_y[i] - my) <= 2)
                        found = m;
                end
                if (found >= 0) begin
                    newhit |= (1 << found);
                    m_valid[i] = 0;
                end else if (m_y[i] < TOP_Y + SPEED) begin
                    m_valid[i] = 0;
                end else begin
                    m_y[i] -= SPEED;
                end
            end
        end
        if (up && m_upq == 0 && m_cd == 0 && free >= 0) begin
            m_valid[free] = 1;
            m_x[free] = int'(tank_x);
            m_y[free] = (int'(tank_y) - SPAWN_OFS + 1024) % 1024;
            m_cd = COOLDOWN;
        end else if (m_cd > 0) begin
            m_cd--;
        end
        m_upq = int'(up);
        m_hit = newhit;
        for (int m = 0; m < 5; m++) if (newhit[m]) cnt++;
        m_score = (m_score + cnt > 255) ? 255 : m_score + cnt;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_active", int'(shots_active), model_active());
        check("cyc_hit", int'(hit), m_hit);
        check("cyc_score", int'(score), m_score);
        check("cyc_pix", int'(shot_pix), model_pix(int'(hCount), int'(vCount)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_up();
        up = 1'b1;
        tick(1);
        up = 1'b0;
    endtask

    task automatic restart();
        up = 1'b0;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic probe(input int h, input int v, output int p);
        hCount = 10'(h);
        vCount = 10'(v);
        #1;
        p = int'(shot_pix);
    endtask

    initial begin
        int p;
        rst = 1'b1; up = 1'b0;
        tank_x = 10'd450; tank_y = 10'd550;
        mons_x = '0; mons_y = '0; mons_alive = '0;
        hCount = '0; vCount = '0;
        #10 rst = 1'b0;
        #10;
        check("rst_active", int'(shots_active), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_score", int'(score), 0);
        check("rst_pix", int'(shot_pix), 0);
        tick(2);
        rst = 1'b1;

        // Basic launch and flight
        pulse_up();
        check("launch_active", int'(shots_active), 1);
        probe(450, 548, p); check("spawn_row", p, 1);
        probe(450, 547, p); check("above_spawn", p, 0);
        tick(10);
        for (int h = 447; h <= 453; h++)
            for (int v = 506; v <= 513; v++) begin
                probe(h, v, p);
                check("pix_after10", p, int'(h >= 449 && h <= 451 && v >= 508 && v <= 511));
            end

        // Held button gives one launch
        restart();
        up = 1'b1;
        tick(20);
        up = 1'b0;
        check("held_one_launch", int'(shots_active), 1);

        // Button toggling with rising edges every 4 ticks against the cooldown
        restart();
        for (int t = 0; t < 40; t++) begin
            up = ((t % 4) < 2);
            tick(1);
            if (t == 8)  check("toggle_t8_rejected", int'(shots_active), 1);
            if (t == 12) check("toggle_t12_second", int'(shots_active), 3);
        end
        up = 1'b0;
        check("toggle_full", int'(shots_active), 15);
        tick(10);
        pulse_up();
        check("full_drop", int'(shots_active), 15);

        // Single hit on monster 2
        restart();
        mons_x[29:20] = 10'd450; mons_y[29:20] = 10'd100; mons_alive = 5'b00100;
        pulse_up();
        tick(112);
        probe(450, 100, p); check("hit_row", p, 1);
        probe(450, 99, p);  check("hit_row_above", p, 0);
        check("hit_before", int'(hit), 0);
        tick(1);
        check("hit_pulse", int'(hit), 4);
        check("hit_cleared", int'(shots_active), 0);
        check("hit_score", int'(score), 1);
        tick(1);
        check("hit_one_cycle", int'(hit), 0);
        check("hit_score_hold", int'(score), 1);

        // Top exit with no live monsters
        restart();
        mons_alive = '0;
        pulse_up();
        tick(127);
        probe(450, 40, p); check("top_row", p, 1);
        check("top_live", int'(shots_active), 1);
        tick(1);
        check("top_cleared", int'(shots_active), 0);
        check("top_no_hit", int'(hit), 0);
        check("top_score", int'(score), 0);

        // Two shots 4 rows apart striking monster 0 together
        restart();
        mons_x[9:0] = 10'd450; mons_y[9:0] = 10'd102; mons_alive = '0;
        tank_y = 10'd550;
        pulse_up();
        tank_y = 10'd518;
        tick(8);
        pulse_up();
        check("dual_active", int'(shots_active), 3);
        tick(103);
        probe(450, 100, p); check("dual_lead_row", p, 1);
        probe(450, 104, p); check("dual_trail_row", p, 1);
        probe(450, 99, p);  check("dual_above", p, 0);
        mons_alive = 5'b00001;
        tick(1);
        check("dual_hit", int'(hit), 1);
        check("dual_cleared", int'(shots_active), 0);
        check("dual_score", int'(score), 1);
        tick(1);
        check("dual_hit_off", int'(hit), 0);
        tank_y = 10'd550;

        // Build score 5 with three live shots, then reset between edges
        restart();
        mons_x[9:0] = 10'd450; mons_y[9:0] = 10'd540; mons_alive = 5'b00001;
        for (int k = 0; k < 5; k++) begin
            pulse_up();
            tick(8);
        end
        check("pre_rst_score", int'(score), 5);
        mons_alive = '0;
        for (int k = 0; k < 3; k++) begin
            pulse_up();
            if (k < 2) tick(8);
        end
        probe(450, 548, p); check("pre_rst_pix", p, 1);
        check("pre_rst_active", int'(shots_active), 7);
        check("pre_rst_score2", int'(score), 5);
        #200;
        rst = 1'b0;
        #1;
        check("async_active", int'(shots_active), 0);
        check("async_pix", int'(shot_pix), 0);
        check("async_score", int'(score), 0);
        check("async_hit", int'(hit), 0);
        tick(1);
        rst = 1'b1;
        tick(2);
        check("post_rst_idle", int'(shots_active), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
